// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decode-side bundle offer, forwarding taps,
// flush, and the registered ALU-side bundle.
//   master: decode/EX environment (drives bundle, taps, out_ready)
//   slave : alu_operand_stage (drives in_ready and registered outputs)
interface alu_operand_stage_if #(
    parameter int DATA_BITS     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int FWD_SRCS      = 2
);
    logic                              in_valid;
    logic                              in_ready;
    logic [REG_ADDR_BITS-1:0]          rs_addr;
    logic [REG_ADDR_BITS-1:0]          rt_addr;
    logic [DATA_BITS-1:0]              reg_out1;
    logic [DATA_BITS-1:0]              reg_out2;
    logic [15:0]                       immediate;
    logic [4:0]                        shamt_in;
    logic                              alu_src_b;
    logic [1:0]                        imm_mode;
    logic                              shamt_sel;
    logic [FWD_SRCS-1:0]               fwd_valid;
    logic [FWD_SRCS*REG_ADDR_BITS-1:0] fwd_addr;
    logic [FWD_SRCS*DATA_BITS-1:0]     fwd_data;
    logic                              flush;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_BITS-1:0]              alu_a;
    logic [DATA_BITS-1:0]              alu_b;
    logic [4:0]                        shamt_out;
    logic [DATA_BITS-1:0]              store_data;

    modport master (
        output in_valid, rs_addr, rt_addr, reg_out1, reg_out2,
        output immediate, shamt_in, alu_src_b, imm_mode, shamt_sel,
        output fwd_valid, fwd_addr, fwd_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, shamt_out, store_data
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, reg_out1, reg_out2,
        input  immediate, shamt_in, alu_src_b, imm_mode, shamt_sel,
        input  fwd_valid, fwd_addr, fwd_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, shamt_out, store_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards rs/rt from later stages, extends the
// immediate, selects shift amount, and registers one bundle behind a
// valid/ready handshake with flush.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_operand_stage_if.slave (bundle in, taps, registered bundle out)
module alu_operand_stage #(
    parameter int DATA_BITS     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int FWD_SRCS      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_stage_if.slave   bus
);
    logic [DATA_BITS-1:0] fwd_rs;
    logic [DATA_BITS-1:0] fwd_rt;
    logic [DATA_BITS-1:0] ext_imm;
    logic [DATA_BITS-1:0] b_next;
    logic [4:0]           shamt_next;
    logic                 accept;

    // Lowest matching index wins: scan from highest to lowest so the
    // last overwrite is the youngest stage. Register 0 never forwards.
    function automatic logic [DATA_BITS-1:0] resolve(
        input logic [REG_ADDR_BITS-1:0]          x,
        input logic [DATA_BITS-1:0]              rf,
        input logic [FWD_SRCS-1:0]               fv,
        input logic [FWD_SRCS*REG_ADDR_BITS-1:0] fa,
        input logic [FWD_SRCS*DATA_BITS-1:0]     fd
    );
        logic [DATA_BITS-1:0] r;
        r = rf;
        for (int i = FWD_SRCS - 1; i >= 0; i--) begin
            if (fv[i] && x != '0 &&
                fa[i*REG_ADDR_BITS +: REG_ADDR_BITS] == x)
                r = fd[i*DATA_BITS +: DATA_BITS];
        end
        return r;
    endfunction

    always_comb begin
        fwd_rs = resolve(bus.rs_addr, bus.reg_out1, bus.fwd_valid,
                         bus.fwd_addr, bus.fwd_data);
        fwd_rt = resolve(bus.rt_addr, bus.reg_out2, bus.fwd_valid,
                         bus.fwd_addr, bus.fwd_data);
    end

    // Mode 3 is reserved and behaves as zero-extend.
    always_comb begin
        ext_imm = '0;
        unique case (bus.imm_mode)
            2'd1: begin
                ext_imm       = {DATA_BITS{bus.immediate[15]}};
                ext_imm[15:0] = bus.immediate;
            end
            2'd2: ext_imm[DATA_BITS-1 -: 16] = bus.immediate;
            2'd0, 2'd3: ext_imm[15:0] = bus.immediate;
        endcase
    end

    always_comb begin
        b_next     = bus.alu_src_b ? ext_imm : fwd_rt;
        shamt_next = bus.shamt_sel ? fwd_rs[4:0] : bus.shamt_in;
    end

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.shamt_out  <= '0;
            bus.store_data <= '0;
        end else begin
            if (accept) begin
                bus.alu_a      <= fwd_rs;
                bus.alu_b      <= b_next;
                bus.shamt_out  <= shamt_next;
                bus.store_data <= fwd_rt;
            end
            if (bus.flush)
                bus.out_valid <= 1'b0;
            else if (accept)
                bus.out_valid <= 1'b1;
            else if (bus.out_ready)
                bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage.
// Drives the bus 1ns after each rising edge and checks there too.
module tb_alu_operand_stage;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    alu_operand_stage_if #(
        .DATA_BITS(32), .REG_ADDR_BITS(5), .FWD_SRCS(2)
    ) bus ();

    alu_operand_stage #(
        .DATA_BITS(32), .REG_ADDR_BITS(5), .FWD_SRCS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.rs_addr   = '0;
        bus.rt_addr   = '0;
        bus.reg_out1  = '0;
        bus.reg_out2  = '0;
        bus.immediate = '0;
        bus.shamt_in  = '0;
        bus.alu_src_b = 1'b0;
        bus.imm_mode  = '0;
        bus.shamt_sel = 1'b0;
        bus.fwd_valid = '0;
        bus.fwd_addr  = '0;
        bus.fwd_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        chk("rst_sd", bus.store_data, 0);
        chk("rst_sh", bus.shamt_out, 0);
        chk("rst_rdy", bus.in_ready, 1);

        // immediate modes
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.immediate = 16'h8001;
        bus.alu_src_b = 1'b1;
        bus.rt_addr   = 5'd7;
        bus.reg_out2  = 32'h12345678;
        bus.imm_mode  = 2'd0;
        tick();
        chk("imm_zero", bus.alu_b, 32'h00008001);
        chk("imm_valid", bus.out_valid, 1);
        chk("imm_sd", bus.store_data, 32'h12345678);
        bus.imm_mode = 2'd1;
        tick();
        chk("imm_sign", bus.alu_b, 32'hFFFF8001);
        bus.imm_mode = 2'd2;
        tick();
        chk("imm_lui", bus.alu_b, 32'h80010000);
        bus.imm_mode = 2'd3;
        tick();
        chk("imm_rsvd", bus.alu_b, 32'h00008001);

        // forwarding priority
        bus.imm_mode  = 2'd0;
        bus.alu_src_b = 1'b0;
        bus.rs_addr   = 5'd5;
        bus.rt_addr   = 5'd5;
        bus.reg_out1  = 32'h0;
        bus.fwd_valid = 2'b11;
        bus.fwd_addr  = {5'd5, 5'd5};
        bus.fwd_data  = {32'h11111111, 32'hAAAA0000};
        tick();
        chk("fwd_src0", bus.alu_a, 32'hAAAA0000);
        chk("fwd_rt_b", bus.alu_b, 32'hAAAA0000);
        chk("fwd_rt_sd", bus.store_data, 32'hAAAA0000);
        bus.fwd_valid = 2'b10;
        tick();
        chk("fwd_src1", bus.alu_a, 32'h11111111);
        bus.fwd_valid = 2'b11;
        bus.fwd_addr  = {5'd0, 5'd0};
        bus.rs_addr   = 5'd0;
        bus.reg_out1  = 32'hCAFEBABE;
        tick();
        chk("fwd_r0", bus.alu_a, 32'hCAFEBABE);

        // backpressure: A then B held off
        bus.fwd_valid = 2'b00;
        bus.rs_addr   = 5'd9;
        bus.reg_out1  = 32'hA0A0A0A0;
        tick();
        chk("bp_loadA", bus.alu_a, 32'hA0A0A0A0);
        bus.out_ready = 1'b0;
        bus.reg_out1  = 32'hB0B0B0B0;
        bus.fwd_valid = 2'b01;
        bus.fwd_addr  = {5'd0, 5'd9};
        bus.fwd_data  = {32'h0, 32'hDEADBEEF};
        #1;
        chk("bp_rdy", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.fwd_data = {32'h0, 32'h5 + 32'(i)};
            chk("bp_hold_a", bus.alu_a, 32'hA0A0A0A0);
            chk("bp_hold_v", bus.out_valid, 1);
        end
        bus.fwd_valid = 2'b00;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_B", bus.alu_a, 32'hB0B0B0B0);
        chk("bp_B_v", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drain_v", bus.out_valid, 0);
        chk("bp_retain", bus.alu_a, 32'hB0B0B0B0);

        // flush with simultaneous offer while holding
        bus.in_valid = 1'b1;
        bus.reg_out1 = 32'h77777777;
        tick();
        chk("fl_pre", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.reg_out1  = 32'h66666666;
        tick();
        chk("fl_valid", bus.out_valid, 0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("fl_stay", bus.out_valid, 0);

        // shift-amount select
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.shamt_sel = 1'b1;
        bus.shamt_in  = 5'd2;
        bus.rs_addr   = 5'd3;
        bus.reg_out1  = 32'h0;
        bus.fwd_valid = 2'b01;
        bus.fwd_addr  = {5'd0, 5'd3};
        bus.fwd_data  = {32'h0, 32'h0000001F};
        tick();
        chk("sh_fwd", bus.shamt_out, 31);
        bus.shamt_sel = 1'b0;
        tick();
        chk("sh_imm", bus.shamt_out, 2);

        // reset mid-transfer
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst2_v", bus.out_valid, 0);
        chk("rst2_a", bus.alu_a, 0);
        chk("rst2_sh", bus.shamt_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ID/EX operand stage between the register file and the ALU; successor to the combinational operand adapter.
- Resolves RAW hazards by forwarding from a parametrised number of later pipeline stages.
- Supports three immediate-extension modes and two shift-amount sources.
- Holds one operand bundle behind a valid/ready handshake, with flush for branch/exception squash.

Parameters:
- DATA_BITS, 32, datapath width (>=16)
- REG_ADDR_BITS, 5, register-file address width
- FWD_SRCS, 2, number of forwarding sources; index 0 = youngest stage (EX/MEM), highest priority

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode offers an operand bundle
- in_ready  out  1  stage accepts the bundle this cycle
- rs_addr  in  REG_ADDR_BITS  source register A address
- rt_addr  in  REG_ADDR_BITS  source register B address
- reg_out1  in  DATA_BITS  register file read port 1 (rs)
- reg_out2  in  DATA_BITS  register file read port 2 (rt)
- immediate  in  16  instruction immediate
- shamt_in  in  5  instruction shamt field
- alu_src_b  in  1  0: B = forwarded rt; 1: B = extended immediate
- imm_mode  in  2  0: zero-extend; 1: sign-extend; 2: immediate in bits [DATA_BITS-1:DATA_BITS-16], low bits zero (LUI); 3: reserved, treated as 0
- shamt_sel  in  1  0: shamt_in; 1: forwarded rs[4:0]
- fwd_valid  in  FWD_SRCS  source i writes back a result
- fwd_addr  in  FWD_SRCS*REG_ADDR_BITS  destination register of source i, packed with i=0 in the LSBs
- fwd_data  in  FWD_SRCS*DATA_BITS  result of source i, packed with i=0 in the LSBs
- flush  in  1  squash the held bundle
- out_valid  out  1  registered bundle valid for the ALU
- out_ready  in  1  EX stage consumes the bundle
- alu_a  out  DATA_BITS  registered operand A (forwarded rs)
- alu_b  out  DATA_BITS  registered operand B
- shamt_out  out  5  registered shift amount
- store_data  out  DATA_BITS  registered forwarded rt, used by stores when alu_src_b=1

Behaviour:
- Reset (rst=1 at edge): out_valid=0; alu_a, alu_b, store_data, shamt_out all 0. Reset dominates flush and load. Reset mid-transfer drops the held bundle.
- in_ready = !out_valid || out_ready, combinational; no combinational path from in_valid to in_ready.
- Load: when in_valid && in_ready && !flush, the next edge sets out_valid=1 and captures the operands. Latency is 1 cycle; throughput is 1 bundle/cycle when out_ready stays high.
- Hold: when out_valid && !out_ready, all outputs are stable and the forwarding inputs are ignored. Operands are resolved only at capture.
- Consume without new load: out_valid goes to 0 next edge; data outputs retain their last values.
- Flush: next edge out_valid=0. A simultaneous in_valid is discarded; data registers may load but are don't-care. in_ready still reflects the formula above.
- Forwarding, per operand (rs or rt address X):
  - Pick the lowest index i with fwd_valid[i] && fwd_addr[i]==X && X!=0; use fwd_data[i].
  - Otherwise use reg_out1/reg_out2.
  - Register 0 is never forwarded: X==0 always yields the register-file value.
  - When several sources match, source 0 wins.
- Immediate extension: sign mode replicates immediate[15] into bits above 15. Zero mode pads with zeros.
- alu_b = alu_src_b ? ext_imm : fwd_rt.
- store_data = fwd_rt, always.
- shamt_out = shamt_sel ? fwd_rs[4:0] : shamt_in.
- alu_a = fwd_rs.
- Purely unsigned bit selection; no arithmetic performed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, all data outputs 0, in_ready=1.
- Immediate modes: imm=16'h8001, alu_src_b=1; imm_mode 0/1/2 -> alu_b = 32'h00008001 / 32'hFFFF8001 / 32'h80010000, one cycle after in_valid.
- Forward priority: rs_addr=5; fwd0 = {valid, addr 5, data 32'hAAAA0000}; fwd1 = {valid, addr 5, data 32'h11111111}; reg_out1 = 32'h0 -> alu_a = 32'hAAAA0000. With fwd0 invalid -> 32'h11111111. With rs_addr=0 and both sources matching addr 0 -> alu_a = reg_out1.
- Backpressure: load bundle A, out_ready=0 for 3 cycles while a new bundle B is offered and fwd_data changes -> in_ready=0, outputs hold A. Set out_ready=1 -> B appears next cycle; nothing is lost or duplicated.
- Flush: flush=1 in the same cycle as in_valid=1 with out_valid=1 -> next cycle out_valid=0; the bundle is not presented.
- Shamt select: shamt_sel=1, rs_addr=3 forwarded with data 32'h0000001F; shamt_in=2 -> shamt_out=31. With shamt_sel=0 -> shamt_out=2.
